// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite compositor and its per-sprite lanes.
package sprite_pkg;

  localparam int unsigned COL_W = 10;
  localparam int unsigned ROW_W = 9;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // Cycles from col/row to composited colour.
  function automatic int unsigned pipe_lat(input int unsigned rom_lat);
    return rom_lat + 2;
  endfunction

  function automatic logic sync_idle(input logic sync_act);
    return ~sync_act;
  endfunction

endpackage

// File: rtl/sprite_lane.sv
// One sprite lane: bounding-box test, clipped ROM address and opacity flag
// aligned with the returning ROM word.
module sprite_lane
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W   = 128,
  parameter int unsigned SPR_H   = 128,
  parameter int unsigned AW      = 14,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic             vga_clk,
  input  logic             arst_n,
  input  logic             en,
  input  logic [COL_W-1:0] col,
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] c,
  input  logic [ROW_W-1:0] r,
  input  logic [15:0]      rom_data,
  output logic [AW-1:0]    rom_addr,
  output logic             opaque
);

  localparam int unsigned      InBoxLen = ROM_LAT + 1;
  localparam logic [COL_W:0]   SprWCol  = SPR_W[COL_W:0];
  localparam logic [ROW_W:0]   SprHRow  = SPR_H[ROW_W:0];
  localparam logic [AW-1:0]    SprWAddr = SPR_W[AW-1:0];

  logic [COL_W:0]    col_end;
  logic [ROW_W:0]    row_end;
  logic              in_box_d;
  logic [COL_W-1:0]  dx;
  logic [ROW_W-1:0]  dy;
  logic [AW-1:0]     addr_d;
  logic [InBoxLen-1:0] in_box_q;

  // One extra bit on the far edge so a sprite hanging off screen clips instead of wrapping.
  assign col_end = {1'b0, c} + SprWCol;
  assign row_end = {1'b0, r} + SprHRow;

  assign in_box_d = en && (col >= c) && ({1'b0, col} < col_end) &&
                    (row >= r) && ({1'b0, row} < row_end);

  assign dx = col - c;
  assign dy = row - r;

  assign addr_d = in_box_d ? (AW'(dy) * SprWAddr + AW'(dx)) : '0;

  always_ff @(posedge vga_clk or negedge arst_n) begin
    if (!arst_n) begin
      rom_addr <= '0;
      in_box_q <= '0;
    end else begin
      rom_addr <= addr_d;
      in_box_q <= {in_box_q[InBoxLen-2:0], in_box_d};
    end
  end

  assign opaque = in_box_q[InBoxLen-1] && (|rom_data);

endmodule

// File: rtl/sprite_compositor.sv
// N-sprite renderer: per-lane box test and ROM addressing, fixed-priority
// composite over background, aligned syncs and per-frame collision report.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 2,
  parameter int unsigned SPR_W       = 128,
  parameter int unsigned SPR_H       = 128,
  parameter int unsigned AW          = 14,
  parameter int unsigned ROM_LAT     = 1,
  parameter logic        SYNC_ACT    = 1'b0
) (
  input  logic                        vga_clk,
  input  logic                        arst_n,
  input  logic [COL_W-1:0]            col,
  input  logic [ROW_W-1:0]            row,
  input  logic                        disp_ena,
  input  logic                        h_sync,
  input  logic                        v_sync,
  input  logic [NUM_SPRITES-1:0]      spr_en,
  input  logic [NUM_SPRITES*COL_W-1:0] spr_c,
  input  logic [NUM_SPRITES*ROW_W-1:0] spr_r,
  input  logic [NUM_SPRITES*12-1:0]   spr_color,
  input  logic [11:0]                 bg_color,
  output logic [NUM_SPRITES*AW-1:0]   rom_addr,
  input  logic [NUM_SPRITES*16-1:0]   rom_data,
  output logic [3:0]                  red,
  output logic [3:0]                  green,
  output logic [3:0]                  blue,
  output logic                        hs_o,
  output logic                        vs_o,
  output logic                        de_o,
  output logic [NUM_SPRITES-1:0]      collision,
  output logic                        collision_valid
);

  localparam int unsigned DlyLen   = pipe_lat(ROM_LAT) - 1;
  localparam logic        SyncIdle = sync_idle(SYNC_ACT);

  logic [NUM_SPRITES-1:0] opaque;
  logic [DlyLen-1:0]      hs_q, vs_q, de_q;
  rgb12_t                 colour_d;
  logic [3:0]             n_opaque;
  logic                   hit;
  logic                   vs_start;
  logic [NUM_SPRITES-1:0] acc_d, acc_q;

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_lane
    sprite_lane #(
      .SPR_W  (SPR_W),
      .SPR_H  (SPR_H),
      .AW     (AW),
      .ROM_LAT(ROM_LAT)
    ) u_lane (
      .vga_clk (vga_clk),
      .arst_n  (arst_n),
      .en      (spr_en[i]),
      .col     (col),
      .row     (row),
      .c       (spr_c[COL_W*i +: COL_W]),
      .r       (spr_r[ROW_W*i +: ROW_W]),
      .rom_data(rom_data[16*i +: 16]),
      .rom_addr(rom_addr[AW*i +: AW]),
      .opaque  (opaque[i])
    );
  end

  always_ff @(posedge vga_clk or negedge arst_n) begin
    if (!arst_n) begin
      hs_q <= {DlyLen{SyncIdle}};
      vs_q <= {DlyLen{SyncIdle}};
      de_q <= '0;
    end else begin
      hs_q <= {hs_q[DlyLen-2:0], h_sync};
      vs_q <= {vs_q[DlyLen-2:0], v_sync};
      de_q <= {de_q[DlyLen-2:0], disp_ena};
    end
  end

  // Walk from the highest index down so the lowest-index opaque sprite wins.
  always_comb begin
    colour_d = rgb12_t'(bg_color);
    for (int i = int'(NUM_SPRITES) - 1; i >= 0; i--) begin
      if (opaque[i]) colour_d = rgb12_t'(spr_color[12*i +: 12]);
    end
    if (!de_q[DlyLen-1]) colour_d = '0;
  end

  always_comb begin
    n_opaque = '0;
    for (int i = 0; i < NUM_SPRITES; i++) n_opaque = n_opaque + 4'(opaque[i]);
  end

  assign hit      = de_q[DlyLen-1] && (n_opaque >= 4'd2);
  assign acc_d    = hit ? (acc_q | opaque) : acc_q;
  // vs_o holds the previous composite-stage vs, so this is the edge into the active level.
  assign vs_start = (vs_q[DlyLen-1] == SYNC_ACT) && (vs_o != SYNC_ACT);

  always_ff @(posedge vga_clk or negedge arst_n) begin
    if (!arst_n) begin
      red             <= '0;
      green           <= '0;
      blue            <= '0;
      hs_o            <= SyncIdle;
      vs_o            <= SyncIdle;
      de_o            <= 1'b0;
      acc_q           <= '0;
      collision       <= '0;
      collision_valid <= 1'b0;
    end else begin
      red             <= colour_d.r;
      green           <= colour_d.g;
      blue            <= colour_d.b;
      hs_o            <= hs_q[DlyLen-1];
      vs_o            <= vs_q[DlyLen-1];
      de_o            <= de_q[DlyLen-1];
      collision_valid <= vs_start;
      if (vs_start) begin
        collision <= acc_d;
        acc_q     <= '0;
      end else begin
        acc_q <= acc_d;
      end
    end
  end

endmodule
